// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status strobes out.
// The master modport is the receiver; the slave modport is the line driver / byte consumer.
interface uart_rx_if;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx_pin,
    output rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    output rx_pin,
    input  rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling of a two-flop synchronised line.
// Emits a one-cycle rx_valid per good byte and a one-cycle frame_err per bad stop bit.
module uart_rx #(
  parameter int SIZE_COUNTER  = 16,
  parameter int LIMIT_COUNTER = 103
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam logic [SIZE_COUNTER-1:0] LIMIT = SIZE_COUNTER'(LIMIT_COUNTER);
  localparam logic [SIZE_COUNTER-1:0] HALF  = SIZE_COUNTER'(LIMIT_COUNTER >> 1);
  localparam logic [SIZE_COUNTER-1:0] ONE   = SIZE_COUNTER'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t                  state, state_next;
  logic [SIZE_COUNTER-1:0] cnt, cnt_next;
  logic [2:0]              bit_idx, bit_idx_next;
  logic [7:0]              shift, shift_next;
  logic [7:0]              rx_data_q, rx_data_next;
  logic                    rx_valid_q, rx_valid_next;
  logic                    frame_err_q, frame_err_next;
  logic                    rx_meta, rx_s;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // Synchroniser flops reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta     <= bus.rx_pin;
      rx_s        <= rx_meta;
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      rx_data_q   <= rx_data_next;
      rx_valid_q  <= rx_valid_next;
      frame_err_q <= frame_err_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    rx_data_next   = rx_data_q;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end

      // Re-check the start bit at its middle; a short glitch is dropped silently.
      START: begin
        if (cnt == HALF) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + ONE;
        end
      end

      DATA: begin
        if (cnt == LIMIT) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end

      STOP: begin
        if (cnt == LIMIT) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_data_next  = shift;
            rx_valid_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HI;
          end
        end else begin
          cnt_next = cnt + ONE;
        end
      end

      // A held-low line (break) must return high before another start is accepted.
      WAIT_HI: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: a TX model drives the line and
// an event log of received bytes / framing errors is compared against expected frames.
module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  logic clk;
  logic rst_n;
  int   cycle;
  int   total;
  int   bad;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t;
  } ev_t;

  ev_t ev_q[$];
  bit  both_seen;

  uart_rx_if bus ();

  uart_rx #(
    .SIZE_COUNTER (4),
    .LIMIT_COUNTER(15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Event log of every strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.rx_valid && bus.frame_err) both_seen = 1'b1;
    if (bus.rx_valid)  ev_q.push_back('{is_err: 1'b0, data: bus.rx_data, t: cycle});
    if (bus.frame_err) ev_q.push_back('{is_err: 1'b1, data: 8'h00, t: cycle});
  end

  // Hold the line at v for n clock edges; returns 1 time unit after the last edge.
  task automatic drive(input logic v, input int n);
    bus.rx_pin = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cycle);
    start_cycle = cycle;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(b[i], BIT_CLKS);
    drive(stop_bit, BIT_CLKS);
  endtask

  task automatic expect_events(input string name, input ev_t exp[$]);
    total++;
    if (ev_q.size() != exp.size()) begin
      bad++;
      $display("FAIL %s event_count actual=%0d required=%0d", name, ev_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        total++;
        if (ev_q[i].is_err !== exp[i].is_err ||
            (!exp[i].is_err && ev_q[i].data !== exp[i].data)) begin
          bad++;
          $display("FAIL %s event[%0d] actual err=%0b data=%h required err=%0b data=%h",
                   name, i, ev_q[i].is_err, ev_q[i].data, exp[i].is_err, exp[i].data);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.rx_pin = 1'b1;
    rst_n      = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy} !== 11'h000) begin
      bad++;
      $display("FAIL reset_outputs actual data=%h v=%b e=%b busy=%b required 00/0/0/0",
               bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
    end
    rst_n = 1'b1;
    drive(1'b1, BIT_CLKS);
    total++;
    if (bus.busy !== 1'b0 || ev_q.size() != 0) begin
      bad++;
      $display("FAIL reset_idle actual busy=%b events=%0d required busy=0 events=0",
               bus.busy, ev_q.size());
    end
  endtask

  task automatic test_single();
    ev_t exp[$];
    int  t0;
    int  lat;
    ev_q.delete();
    send_frame(8'h9A, 1'b1, t0);
    drive(1'b1, 4);
    exp.push_back('{is_err: 1'b0, data: 8'h9A, t: 0});
    expect_events("single_9a", exp);
    lat = (ev_q.size() > 0) ? ev_q[0].t - t0 : -1;
    total++;
    if (lat < 154 || lat > 156) begin
      bad++;
      $display("FAIL single_latency actual=%0d required=154..156", lat);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.rx_data !== 8'h9A) begin
      bad++;
      $display("FAIL single_after actual busy=%b data=%h required busy=0 data=9a",
               bus.busy, bus.rx_data);
    end
  endtask

  task automatic test_back_to_back();
    ev_t exp[$];
    int  t0;
    ev_q.delete();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t0);
    drive(1'b1, 20);
    exp.push_back('{is_err: 1'b0, data: 8'h00, t: 0});
    exp.push_back('{is_err: 1'b0, data: 8'hFF, t: 0});
    expect_events("back_to_back", exp);
  endtask

  task automatic test_glitch();
    ev_t exp[$];
    int  t0;
    ev_q.delete();
    drive(1'b0, 4);
    drive(1'b1, 2 * BIT_CLKS);
    total++;
    if (ev_q.size() != 0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_reject actual events=%0d busy=%b required 0/0", ev_q.size(), bus.busy);
    end
    send_frame(8'h55, 1'b1, t0);
    drive(1'b1, 20);
    exp.push_back('{is_err: 1'b0, data: 8'h55, t: 0});
    expect_events("glitch_then_55", exp);
  endtask

  task automatic test_break();
    ev_t exp[$];
    int  t0;
    ev_q.delete();
    send_frame(8'hA5, 1'b0, t0);
    drive(1'b0, 64);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL break_busy_held actual=%b required=1", bus.busy);
    end
    drive(1'b1, 8);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL break_busy_release actual=%b required=0", bus.busy);
    end
    total++;
    if (bus.rx_data !== 8'h55) begin
      bad++;
      $display("FAIL break_data_kept actual=%h required=55", bus.rx_data);
    end
    drive(1'b1, 2 * BIT_CLKS);
    exp.push_back('{is_err: 1'b1, data: 8'h00, t: 0});
    expect_events("break", exp);
  endtask

  task automatic test_reset_mid_frame();
    ev_t        exp[$];
    int         t0;
    logic [7:0] b;
    b = 8'h3C;
    ev_q.delete();
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(b[i], BIT_CLKS);
    drive(b[4], BIT_CLKS / 2);
    rst_n = 1'b0;
    drive(b[4], 2);
    total++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy} !== 11'h000) begin
      bad++;
      $display("FAIL midreset_outputs actual data=%h v=%b e=%b busy=%b required 00/0/0/0",
               bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
    end
    rst_n = 1'b1;
    drive(1'b1, 2 * BIT_CLKS);
    total++;
    if (ev_q.size() != 0 || bus.busy !== 1'b0 || bus.rx_data !== 8'h00) begin
      bad++;
      $display("FAIL midreset_quiet actual events=%0d busy=%b data=%h required 0/0/00",
               ev_q.size(), bus.busy, bus.rx_data);
    end
    send_frame(8'hC3, 1'b1, t0);
    drive(1'b1, 20);
    exp.push_back('{is_err: 1'b0, data: 8'hC3, t: 0});
    expect_events("after_reset_c3", exp);
  endtask

  // Random frames, occasionally with a bad stop bit; the model is simply the frame list:
  // good stop -> byte delivered, bad stop -> one error and the last good byte retained.
  task automatic test_random();
    ev_t        exp[$];
    int         t0;
    logic [7:0] b;
    logic       stop_ok;
    logic [7:0] last_good;
    last_good = bus.rx_data;
    ev_q.delete();
    for (int n = 0; n < 16; n++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_ok, t0);
      if (stop_ok) begin
        exp.push_back('{is_err: 1'b0, data: b, t: 0});
        last_good = b;
        drive(1'b1, $urandom_range(0, 12));
      end else begin
        exp.push_back('{is_err: 1'b1, data: 8'h00, t: 0});
        drive(1'b1, BIT_CLKS + $urandom_range(0, 12));
      end
    end
    drive(1'b1, 20);
    expect_events("random", exp);
    total++;
    if (bus.rx_data !== last_good) begin
      bad++;
      $display("FAIL random_last_data actual=%h required=%h", bus.rx_data, last_good);
    end
    total++;
    if (both_seen) begin
      bad++;
      $display("FAIL strobes_exclusive actual=both_high required=never");
    end
  endtask

  initial begin
    cycle     = 0;
    total     = 0;
    bad       = 0;
    both_seen = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
